modulo_counter_n: RTL and testbench
===================================

MODULO_COUNTER_N -- requirements
Module: modulo_counter_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of cascaded digits, legal range 1..8.
REQ-002 SHALL have parameter MODULUS, default 10: count modulus of each digit, legal range 2..16.
REQ-003 SHALL use derived width DW = $clog2(MODULUS) bits per digit.
REQ-004 SHALL have port CLK, input, 1: the single clock; all state updates on posedge.
REQ-005 SHALL have port MR_n, input, 1: asynchronous, active-low master reset.
REQ-006 SHALL have port Load, input, 1: synchronous parallel load.
REQ-007 SHALL have port Enable, input, 1: count enable.
REQ-008 SHALL have port CI, input, 1: cascade-in enable, driven by the previous stage's TC; tie to 1 when unused.
REQ-009 SHALL have port Up, input, 1: count direction; 1 counts up, 0 counts down.
REQ-010 SHALL have port P, input, DIGITS*DW: parallel load value; digit i is P[i*DW +: DW], digit 0 least significant.
REQ-011 SHALL have port Q, output, DIGITS*DW: count value, registered, same digit packing as P.
REQ-012 SHALL have port TC, output, 1: terminal count, combinational.
REQ-013 SHALL have port LdErr, output, 1: registered flag indicating that a load clamped an illegal digit.

Function
REQ-014 SHALL apply the priority MR_n low > Load > count > hold.
REQ-015 SHALL, when Load=1 at a posedge, load P into Q irrespective of Enable, CI and Up.
REQ-016 SHALL clamp any loaded digit with a value >= MODULUS to MODULUS-1.
REQ-017 SHALL set LdErr=1 in the cycle after a load in which any digit was clamped, otherwise 0; LdErr SHALL self-clear at the next posedge.
REQ-018 SHALL perform a count step at a posedge when Enable=1, CI=1 and Load=0; otherwise Q SHALL hold.
REQ-019 SHALL, on an up step, increment digit 0; digit i>0 SHALL increment only when all lower digits equal MODULUS-1; a digit at MODULUS-1 that steps SHALL wrap to 0.
REQ-020 SHALL, on a down step, decrement digit 0; digit i>0 SHALL decrement only when all lower digits equal 0; a digit at 0 that steps SHALL wrap to MODULUS-1.
REQ-021 SHALL wrap the full count from MODULUS^DIGITS-1 to 0 (up) and from 0 to MODULUS^DIGITS-1 (down) with no stall cycle.
REQ-022 SHALL drive TC = CI AND (Up ? all digits == MODULUS-1 : all digits == 0); TC SHALL NOT be gated by Enable.
REQ-023 SHALL sample Up every cycle; a direction change SHALL take effect on the same posedge with no extra latency.
REQ-024 SHALL never allow any digit of Q to hold a value >= MODULUS.
REQ-025 SHALL, when MODULUS is a power of two, never assert LdErr.
REQ-026 SHALL stop elaboration with an error when a parameter is outside its legal range.

Reset
REQ-027 SHALL, while MR_n=0, force Q=0 and LdErr=0 immediately, without waiting for CLK, and hold those values for as long as MR_n stays low.
REQ-028 SHALL ignore Load and count requests while MR_n=0.
REQ-029 SHALL treat MR_n release as synchronous to operation; the first load or count SHALL occur at the first posedge at which MR_n=1.
REQ-030 SHALL drive TC from the reset value of Q during reset, i.e. TC = CI AND NOT Up.

Verification (bench parameters: DIGITS=2, MODULUS=10; Q values shown as digits)
REQ-031 SHALL check up-count wrap: reset, then Enable=CI=Up=1 for 101 cycles -> Q steps 00,01..99,00; TC=1 only while Q=99.
REQ-032 SHALL check load and hold: Load=1 with P=4,7 -> Q=47 at the next posedge; then Enable=0 for 5 cycles -> Q stays 47.
REQ-033 SHALL check down-count wrap: from Q=00, Up=0, Enable=CI=1 -> TC=1 at 00, then Q=99,98; digit 1 decrements only at x0->(x-1)9.
REQ-034 SHALL check clamping: Load P=A,5 -> Q=95 and LdErr=1 for exactly one cycle; a following load of P=3,2 -> Q=32 and LdErr=0.
REQ-035 SHALL check reset mid-operation: MR_n pulled low between posedges while counting at 63 -> Q=00 before the next posedge; Load=1 held during reset has no effect; counting resumes 00->01 at the first posedge after release.
REQ-036 SHALL check simultaneous and cascade events: Load=1 and Enable=1 at the same edge with P=1,9 -> Q=19, no increment; CI=0 with Enable=1 -> Q holds and TC=0.

Source files
------------

// File: rtl/modulo_counter_n_if.sv
// ---------------------------------------------------------------------------
// modulo_counter_n_if
//   Bundles the control, data and status signals of modulo_counter_n so the
//   counter and whatever drives it share one typed connection.
//
//   Parameters
//     DIGITS  : number of cascaded digits
//     MODULUS : count modulus of each digit
//
//   Signals (direction as seen from the counter, i.e. the slave modport)
//     Load   in   synchronous parallel load
//     Enable in   count enable
//     CI     in   cascade-in enable (previous stage TC, tie to 1 if unused)
//     Up     in   count direction, 1 = up, 0 = down
//     P      in   parallel load value, digit i at P[i*DW +: DW]
//     Q      out  registered count value, same packing as P
//     TC     out  combinational terminal count
//     LdErr  out  registered flag, a load clamped an out-of-range digit
// ---------------------------------------------------------------------------
interface modulo_counter_n_if #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
);

  localparam int DW = $clog2(MODULUS);

  logic                   Load;
  logic                   Enable;
  logic                   CI;
  logic                   Up;
  logic [DIGITS*DW-1:0]   P;
  logic [DIGITS*DW-1:0]   Q;
  logic                   TC;
  logic                   LdErr;

  // Driver side: owns the controls and the load value.
  modport master (
    output Load,
    output Enable,
    output CI,
    output Up,
    output P,
    input  Q,
    input  TC,
    input  LdErr
  );

  // Counter side.
  modport slave (
    input  Load,
    input  Enable,
    input  CI,
    input  Up,
    input  P,
    output Q,
    output TC,
    output LdErr
  );

endinterface

// File: rtl/modulo_counter_n.sv
// ---------------------------------------------------------------------------
// modulo_counter_n
//   Cascaded up/down counter of DIGITS digits, each counting modulo MODULUS.
//   Digit 0 is least significant. Supports synchronous parallel load with
//   clamping of out-of-range digits, a cascade-in enable, and a terminal
//   count output for chaining further stages.
//
//   Priority: MR_n low > Load > count > hold.
//
//   Ports
//     CLK   in   single clock, all state changes on posedge
//     MR_n  in   asynchronous active-low master reset (Q = 0, LdErr = 0)
//     bus   slave modport of modulo_counter_n_if carrying Load, Enable, CI,
//                Up, P (inputs) and Q, TC, LdErr (outputs)
// ---------------------------------------------------------------------------
module modulo_counter_n #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
) (
  input  logic              CLK,
  input  logic              MR_n,
  modulo_counter_n_if.slave bus
);

  localparam int              DW        = $clog2(MODULUS);
  localparam int              QW        = DIGITS * DW;
  localparam logic [DW-1:0]   DIGIT_MAX = DW'(MODULUS - 1);
  localparam logic [DW-1:0]   DIGIT_ONE = DW'(1);

  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("modulo_counter_n: DIGITS=%0d outside legal range 1..8", DIGITS);
    end
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
      $error("modulo_counter_n: MODULUS=%0d outside legal range 2..16", MODULUS);
    end
  endgenerate

  logic [QW-1:0]     q_q;
  logic [QW-1:0]     q_d;
  logic              lderr_q;
  logic              lderr_d;

  logic [QW-1:0]     load_val;
  logic              load_clamped;
  logic [QW-1:0]     step_val;
  logic              carry;
  logic [DIGITS-1:0] digit_max;
  logic [DIGITS-1:0] digit_zero;
  logic              all_max;
  logic              all_zero;
  logic              tc;

  // Per-digit terminal detection, shared by the step logic and TC.
  always_comb begin
    digit_max  = '0;
    digit_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_max[i]  = (q_q[i*DW +: DW] == DIGIT_MAX);
      digit_zero[i] = (q_q[i*DW +: DW] == '0);
    end
  end

  assign all_max  = &digit_max;
  assign all_zero = &digit_zero;

  // Load value with clamping. When MODULUS is a power of two every DW-bit
  // pattern is legal, so the compare is never true and LdErr stays low.
  always_comb begin
    load_val     = '0;
    load_clamped = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.P[i*DW +: DW] > DIGIT_MAX) begin
        load_val[i*DW +: DW] = DIGIT_MAX;
        load_clamped         = 1'b1;
      end else begin
        load_val[i*DW +: DW] = bus.P[i*DW +: DW];
      end
    end
  end

  // One count step. The carry/borrow ripples upward: a digit steps only
  // while every lower digit sits at its terminal value for the current
  // direction, so the full count wraps in a single cycle.
  always_comb begin
    step_val = q_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bus.Up) begin
          step_val[i*DW +: DW] = digit_max[i]  ? '0        : q_q[i*DW +: DW] + DIGIT_ONE;
        end else begin
          step_val[i*DW +: DW] = digit_zero[i] ? DIGIT_MAX : q_q[i*DW +: DW] - DIGIT_ONE;
        end
      end
      carry = carry & (bus.Up ? digit_max[i] : digit_zero[i]);
    end
  end

  // Next-state selection; LdErr defaults low so it self-clears one cycle
  // after a clamping load.
  always_comb begin
    q_d     = q_q;
    lderr_d = 1'b0;
    if (bus.Load) begin
      q_d     = load_val;
      lderr_d = load_clamped;
    end else if (bus.Enable && bus.CI) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      q_q     <= '0;
      lderr_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      lderr_q <= lderr_d;
    end
  end

  // TC is not gated by Enable so a following stage can see the terminal
  // state even while this stage is paused.
  assign tc = bus.CI & (bus.Up ? all_max : all_zero);

  assign bus.Q     = q_q;
  assign bus.TC    = tc;
  assign bus.LdErr = lderr_q;

endmodule

// File: tb/tb_modulo_counter_n.sv
// ---------------------------------------------------------------------------
// tb_modulo_counter_n
//   Self-checking bench for modulo_counter_n with DIGITS=2, MODULUS=10, so
//   the packed Q value reads as two BCD digits (8'h47 is count 47).
//   Stimulus pushes the expected post-edge state into a scoreboard queue;
//   an independent monitor pops and compares after each posedge, or right
//   away when an asynchronous event is flagged.
// ---------------------------------------------------------------------------
module tb_modulo_counter_n;

  localparam int DIGITS  = 2;
  localparam int MODULUS = 10;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       tc;
    logic       lderr;
  } expect_t;

  logic    clk;
  logic    mr_n;
  expect_t scoreboard[$];
  event    async_check;
  int      assertions_evaluated = 0;
  int      failures             = 0;

  modulo_counter_n_if #(.DIGITS(DIGITS), .MODULUS(MODULUS)) bus ();

  modulo_counter_n #(.DIGITS(DIGITS), .MODULUS(MODULUS)) dut (
    .CLK  (clk),
    .MR_n (mr_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decimal count value to the two-digit packed form.
  function automatic logic [7:0] to_q(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input expect_t e);
    assertions_evaluated++;
    if (bus.Q !== e.q) begin
      failures++;
      $display("[TB] FAIL %s Q: got %h expected %h", e.name, bus.Q, e.q);
    end
    assertions_evaluated++;
    if (bus.TC !== e.tc) begin
      failures++;
      $display("[TB] FAIL %s TC: got %b expected %b", e.name, bus.TC, e.tc);
    end
    assertions_evaluated++;
    if (bus.LdErr !== e.lderr) begin
      failures++;
      $display("[TB] FAIL %s LdErr: got %b expected %b", e.name, bus.LdErr, e.lderr);
    end
  endtask

  // Expectation for the present moment rather than the next edge.
  task automatic pushNow(input string name, input logic [7:0] q, input logic tc, input logic lderr);
    expect_t e;
    e.name  = name;
    e.q     = q;
    e.tc    = tc;
    e.lderr = lderr;
    scoreboard.push_back(e);
    -> async_check;
    #2;
  endtask

  // Drive one cycle of inputs at the negedge and queue the state expected
  // just after the following posedge.
  task automatic applyStimulus(input logic rst_v, input logic load, input logic enable,
                               input logic ci, input logic up, input logic [7:0] p,
                               input string name, input logic [7:0] q,
                               input logic tc, input logic lderr);
    expect_t e;
    @(negedge clk);
    mr_n       = rst_v;
    bus.Load   = load;
    bus.Enable = enable;
    bus.CI     = ci;
    bus.Up     = up;
    bus.P      = p;
    e.name  = name;
    e.q     = q;
    e.tc    = tc;
    e.lderr = lderr;
    scoreboard.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares whatever the stimulus queued once the DUT has settled.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk or async_check);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    mr_n       = 1'b1;
    bus.Load   = 1'b0;
    bus.Enable = 1'b0;
    bus.CI     = 1'b1;
    bus.Up     = 1'b1;
    bus.P      = 8'h00;
    #1 mr_n = 1'b0;
    #2;

    // Reset state, TC follows CI & ~Up.
    pushNow("reset up", 8'h00, 1'b0, 1'b0);
    bus.Up = 1'b0;
    #1;
    pushNow("reset down tc", 8'h00, 1'b1, 1'b0);

    // Load and count requested while reset is held are ignored.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, "reset ignores load", 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "reset ignores count", 8'h00, 1'b0, 1'b0);

    // Up-count through the full range and wrap back to 00.
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, $sformatf("up step %0d", i),
                    to_q(i % 100), ((i % 100) == 99), 1'b0);
    end

    // Load and hold.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h47, "load 47", 8'h47, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, $sformatf("hold 47 #%0d", i),
                    8'h47, 1'b0, 1'b0);
    end

    // Down-count from 00 with wrap, across the 90 -> 89 borrow.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "load 00 down", 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("down step %0d", i),
                    to_q(100 - i), 1'b0, 1'b0);
    end

    // Clamping of illegal digits and LdErr self-clear.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, "clamp A5", 8'h95, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "lderr clears", 8'h95, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h32, "load 32", 8'h32, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5C, "clamp 5C", 8'h59, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, "clamp FF", 8'h99, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "wrap after clamp", 8'h00, 1'b0, 1'b0);

    // Reset asserted mid-cycle while counting at 63.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h62, "load 62", 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "count 63", 8'h63, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    mr_n     = 1'b0;
    bus.Load = 1'b1;
    bus.P    = 8'h47;
    #1;
    pushNow("async reset", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h47, "reset holds vs load", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "resume 01", 8'h01, 1'b0, 1'b0);

    // Load beats count; CI gates both stepping and TC.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h19, "load beats count", 8'h19, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "ci low holds", 8'h19, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, "load 99 ci low", 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "tc without enable", 8'h99, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "ci low at 99", 8'h99, 1'b0, 1'b0);

    // Direction change takes effect on the same edge.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "down from 99", 8'h98, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "up to 99", 8'h99, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    assertions_evaluated++;
    if (scoreboard.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
